// File: rtl/vga_scan_if.sv
// Signal bundle between the scan controller, the video RAM read port and the VGA pins.
`timescale 1ns/1ps
interface vga_scan_if #(
   parameter int ADDR_W = 14
);
   // No valid/ready: the VRAM answers a fixed one clock after pixel_addr, and the
   // pin-side outputs are free-running, changing only on pixel ticks.
   logic              red_in;
   logic              green_in;
   logic              blue_in;
   logic [ADDR_W-1:0] pixel_addr;
   logic              VGA_Red;
   logic              VGA_Green;
   logic              VGA_Blue;
   logic              VGA_HSYNC;
   logic              VGA_VSYNC;
   logic              video_on;
   logic              frame_start;
   logic [1:0]        dbg_h_state;
   logic [1:0]        dbg_v_state;

   modport master (
      input  red_in, green_in, blue_in,
      output pixel_addr, VGA_Red, VGA_Green, VGA_Blue, VGA_HSYNC, VGA_VSYNC,
      output video_on, frame_start, dbg_h_state, dbg_v_state
   );

   modport slave (
      output red_in, green_in, blue_in,
      input  pixel_addr, VGA_Red, VGA_Green, VGA_Blue, VGA_HSYNC, VGA_VSYNC,
      input  video_on, frame_start, dbg_h_state, dbg_v_state
   );
endinterface

// File: rtl/vga_scan_controller.sv
// 640x480@60 VGA timing on a 25 MHz pixel tick derived from 50 MHz, scanning a
// 128x96 VRAM with each stored pixel replicated into a 5x5 screen block.
`timescale 1ns/1ps
module vga_scan_controller #(
   parameter int H_DISP = 640,
   parameter int H_FP   = 16,
   parameter int H_SYNC = 96,
   parameter int H_BP   = 48,
   parameter int V_DISP = 480,
   parameter int V_FP   = 10,
   parameter int V_SYNC = 2,
   parameter int V_BP   = 33,
   parameter int SCALE  = 5,
   parameter int MEM_W  = 128,
   parameter int ADDR_W = 14
) (
   input  logic       clk,
   input  logic       reset,
   vga_scan_if.master vga
);

   typedef enum logic [1:0] {
      ST_H_DISPLAY = 2'd0,
      ST_H_FRONT   = 2'd1,
      ST_H_SYNC    = 2'd2,
      ST_H_BACK    = 2'd3
   } h_state_t;

   typedef enum logic [1:0] {
      ST_V_DISPLAY = 2'd0,
      ST_V_FRONT   = 2'd1,
      ST_V_SYNC    = 2'd2,
      ST_V_BACK    = 2'd3
   } v_state_t;

   localparam logic [9:0]        H_DISP_LAST = 10'(H_DISP - 1);
   localparam logic [9:0]        H_FP_LAST   = 10'(H_FP - 1);
   localparam logic [9:0]        H_SYNC_LAST = 10'(H_SYNC - 1);
   localparam logic [9:0]        H_BP_LAST   = 10'(H_BP - 1);
   localparam logic [9:0]        V_DISP_LAST = 10'(V_DISP - 1);
   localparam logic [9:0]        V_FP_LAST   = 10'(V_FP - 1);
   localparam logic [9:0]        V_SYNC_LAST = 10'(V_SYNC - 1);
   localparam logic [9:0]        V_BP_LAST   = 10'(V_BP - 1);
   localparam logic [2:0]        SUB_LAST    = 3'(SCALE - 1);
   localparam logic [ADDR_W-1:0] ROW_STEP    = ADDR_W'(MEM_W);

   function automatic logic [9:0] h_last(input h_state_t s);
      case (s)
         ST_H_DISPLAY: h_last = H_DISP_LAST;
         ST_H_FRONT:   h_last = H_FP_LAST;
         ST_H_SYNC:    h_last = H_SYNC_LAST;
         default:      h_last = H_BP_LAST;
      endcase
   endfunction

   function automatic logic [9:0] v_last(input v_state_t s);
      case (s)
         ST_V_DISPLAY: v_last = V_DISP_LAST;
         ST_V_FRONT:   v_last = V_FP_LAST;
         ST_V_SYNC:    v_last = V_SYNC_LAST;
         default:      v_last = V_BP_LAST;
      endcase
   endfunction

   logic              phase_q;
   logic              run_q;
   h_state_t          h_state_q;
   v_state_t          v_state_q;
   logic [9:0]        h_cnt_q;
   logic [9:0]        v_cnt_q;
   logic [2:0]        col_sub_q, col_sub_d;
   logic [2:0]        row_sub_q, row_sub_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] line_base_q, line_base_d;
   logic              red_q, green_q, blue_q;
   logic              hsync_q, vsync_q;
   logic              video_on_q;
   logic              frame_start_q;

   logic tick;
   logic adv;
   logic visible;

   // The first tick after reset only presents address 0 to the VRAM; the
   // counters start moving one tick later, once that read has come back.
   assign tick    = ~phase_q;
   assign adv     = tick & run_q;
   assign visible = (h_state_q == ST_H_DISPLAY) && (v_state_q == ST_V_DISPLAY);

   always_comb begin
      col_sub_d   = col_sub_q;
      row_sub_d   = row_sub_q;
      addr_d      = addr_q;
      line_base_d = line_base_q;
      if (adv && visible) begin
         if (h_cnt_q == H_DISP_LAST) begin
            col_sub_d = 3'd0;
            if (v_cnt_q == V_DISP_LAST) begin
               row_sub_d   = 3'd0;
               line_base_d = '0;
               addr_d      = '0;
            end else if (row_sub_q == SUB_LAST) begin
               row_sub_d   = 3'd0;
               line_base_d = line_base_q + ROW_STEP;
               addr_d      = line_base_q + ROW_STEP;
            end else begin
               row_sub_d = row_sub_q + 3'd1;
               addr_d    = line_base_q;
            end
         end else if (col_sub_q == SUB_LAST) begin
            col_sub_d = 3'd0;
            addr_d    = addr_q + 1'b1;
         end else begin
            col_sub_d = col_sub_q + 3'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         phase_q       <= 1'b0;
         run_q         <= 1'b0;
         h_state_q     <= ST_H_DISPLAY;
         v_state_q     <= ST_V_DISPLAY;
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         col_sub_q     <= '0;
         row_sub_q     <= '0;
         addr_q        <= '0;
         line_base_q   <= '0;
         red_q         <= 1'b0;
         green_q       <= 1'b0;
         blue_q        <= 1'b0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         video_on_q    <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         phase_q       <= ~phase_q;
         frame_start_q <= 1'b0;
         col_sub_q     <= col_sub_d;
         row_sub_q     <= row_sub_d;
         addr_q        <= addr_d;
         line_base_q   <= line_base_d;
         if (tick && !run_q) begin
            run_q <= 1'b1;
         end
         if (adv) begin
            // Pin outputs describe the pixel the counters held before this tick,
            // which is the pixel whose VRAM data is arriving now.
            red_q         <= vga.red_in & visible;
            green_q       <= vga.green_in & visible;
            blue_q        <= vga.blue_in & visible;
            video_on_q    <= visible;
            hsync_q       <= (h_state_q != ST_H_SYNC);
            vsync_q       <= (v_state_q != ST_V_SYNC);
            frame_start_q <= visible && (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);

            if (h_cnt_q == h_last(h_state_q)) begin
               h_cnt_q <= '0;
               case (h_state_q)
                  ST_H_DISPLAY: h_state_q <= ST_H_FRONT;
                  ST_H_FRONT:   h_state_q <= ST_H_SYNC;
                  ST_H_SYNC:    h_state_q <= ST_H_BACK;
                  default: begin
                     h_state_q <= ST_H_DISPLAY;
                     if (v_cnt_q == v_last(v_state_q)) begin
                        v_cnt_q <= '0;
                        case (v_state_q)
                           ST_V_DISPLAY: v_state_q <= ST_V_FRONT;
                           ST_V_FRONT:   v_state_q <= ST_V_SYNC;
                           ST_V_SYNC:    v_state_q <= ST_V_BACK;
                           default:      v_state_q <= ST_V_DISPLAY;
                        endcase
                     end else begin
                        v_cnt_q <= v_cnt_q + 10'd1;
                     end
                  end
               endcase
            end else begin
               h_cnt_q <= h_cnt_q + 10'd1;
            end
         end
      end
   end

   assign vga.pixel_addr  = addr_q;
   assign vga.VGA_Red     = red_q;
   assign vga.VGA_Green   = green_q;
   assign vga.VGA_Blue    = blue_q;
   assign vga.VGA_HSYNC   = hsync_q;
   assign vga.VGA_VSYNC   = vsync_q;
   assign vga.video_on    = video_on_q;
   assign vga.frame_start = frame_start_q;
   assign vga.dbg_h_state = h_state_q;
   assign vga.dbg_v_state = v_state_q;

endmodule

// File: tb/tb_vga_scan_controller.sv
// Bench for vga_scan_controller: full horizontal timing with a shortened vertical
// frame (10 visible lines) so several frames fit in a short run.
`timescale 1ns/1ps
module tb_vga_scan_controller;

   localparam int V_DISP_T   = 10;
   localparam int LINE_CLK   = 1600;
   localparam int FRAME_CLK  = 14 * LINE_CLK;
   localparam int VO_CLK     = V_DISP_T * 1280;
   localparam int LAST_ADDR  = (V_DISP_T / 5) * 128 - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;

   vga_scan_if #(.ADDR_W(14)) vif ();

   vga_scan_controller #(
      .V_DISP(V_DISP_T), .V_FP(1), .V_SYNC(2), .V_BP(1)
   ) dut (
      .clk   (clk),
      .reset (rst),
      .vga   (vif)
   );

   // ---------------- clock / reset bookkeeping ----------------
   always #10 clk = ~clk;

   bit rst_seen = 1'b1;
   bit tb_ph    = 1'b0;
   always @(posedge clk) begin
      rst_seen <= rst;
      tb_ph    <= rst ? 1'b0 : ~tb_ph;
   end

   // ---------------- scoreboard state ----------------
   logic [16:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   function automatic logic [2:0] vram_f(input logic [13:0] a);
      return ~{a[0], a[1] ^ a[7], a[2] ^ a[8]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push_frames(input int n);
      logic [13:0] a;
      for (int f = 0; f < n; f++)
         for (int ln = 0; ln < V_DISP_T; ln++)
            for (int c = 0; c < 640; c++) begin
               a = 14'((ln / 5) * 128 + c / 5);
               exp_q.push_back({a, vram_f(a)});
            end
   endtask

   task automatic check_reset(input string pfx);
      check({pfx, "_addr"},   32'(vif.pixel_addr), 0);
      check({pfx, "_rgb"},    32'({vif.VGA_Red, vif.VGA_Green, vif.VGA_Blue}), 0);
      check({pfx, "_hsync"},  32'(vif.VGA_HSYNC), 1);
      check({pfx, "_vsync"},  32'(vif.VGA_VSYNC), 1);
      check({pfx, "_vo"},     32'(vif.video_on), 0);
      check({pfx, "_fs"},     32'(vif.frame_start), 0);
      check({pfx, "_hstate"}, 32'(vif.dbg_h_state), 0);
      check({pfx, "_vstate"}, 32'(vif.dbg_v_state), 0);
   endtask

   // ---------------- VRAM model: data one clk after the address ----------------
   initial begin
      vif.red_in   = 1'b0;
      vif.green_in = 1'b0;
      vif.blue_in  = 1'b0;
      forever begin
         @(posedge clk);
         #1 {vif.red_in, vif.green_in, vif.blue_in} = vram_f(vif.pixel_addr);
      end
   end

   // ---------------- monitor ----------------
   int cyc = 0;
   int tick_idx, first_tick_cyc;
   bit addr_chk_done;
   logic [13:0] prev_addr = '0;
   logic [13:0] max_addr = '0;
   logic [16:0] e;
   logic p_hs = 1'b1, p_vs = 1'b1, p_vo = 1'b0, p_fs = 1'b0;
   logic hs, vs, vo, fs;
   bit have_hs, have_vs, have_fs, vo_pend;
   int hs_fall_t, vs_fall_t, fs_t, vo_rise_t;
   int vo_clks, fs_high, vs_falls;
   int fs_rises = 0;
   int blank_err = 0;

   always @(negedge clk) begin
      cyc++;
      if (rst_seen) begin
         tick_idx = 0; addr_chk_done = 0; prev_addr = '0;
         have_hs = 0; have_vs = 0; have_fs = 0; vo_pend = 0;
         p_hs = 1'b1; p_vs = 1'b1; p_vo = 1'b0; p_fs = 1'b0;
         vo_clks = 0; fs_high = 0; vs_falls = 0;
      end else begin
         if (tb_ph) begin
            tick_idx++;
            if (tick_idx == 1) first_tick_cyc = cyc;
            if (!addr_chk_done && vif.pixel_addr != prev_addr) begin
               check("first_addr_change_tick_ge6", 32'(tick_idx >= 6), 1);
               addr_chk_done = 1;
            end
            if (vif.video_on) begin
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL sb_underflow: pixel output with empty expected queue at cycle %0d", cyc);
               end else begin
                  e = exp_q.pop_front();
                  check("pixel_addr", 32'(prev_addr), 32'(e[16:3]));
                  check("pixel_rgb", 32'({vif.VGA_Red, vif.VGA_Green, vif.VGA_Blue}), 32'(e[2:0]));
               end
            end
            if (vif.pixel_addr > max_addr) max_addr = vif.pixel_addr;
            prev_addr = vif.pixel_addr;
         end

         hs = vif.VGA_HSYNC; vs = vif.VGA_VSYNC; vo = vif.video_on; fs = vif.frame_start;
         if (p_hs && !hs) begin
            if (have_hs) check("hsync_period", 32'(cyc - hs_fall_t), LINE_CLK);
            if (vo_pend) check("hsync_fall_after_video", 32'(cyc - vo_rise_t), 1312);
            vo_pend = 0; hs_fall_t = cyc; have_hs = 1;
         end
         if (!p_hs && hs && have_hs) check("hsync_low", 32'(cyc - hs_fall_t), 192);
         if (!p_vo && vo) begin vo_rise_t = cyc; vo_pend = 1; end
         if (p_vs && !vs) begin vs_fall_t = cyc; have_vs = 1; vs_falls++; end
         if (!p_vs && vs && have_vs) check("vsync_low", 32'(cyc - vs_fall_t), 3200);
         if (!p_fs && fs) begin
            if (have_fs) begin
               check("frame_period", 32'(cyc - fs_t), FRAME_CLK);
               check("video_on_clks", 32'(vo_clks), VO_CLK);
               check("frame_start_width", 32'(fs_high), 1);
               check("vsync_per_frame", 32'(vs_falls), 1);
            end else begin
               check("fs_after_first_tick", 32'(cyc - first_tick_cyc), 2);
            end
            fs_t = cyc; have_fs = 1; fs_rises++;
            vo_clks = 0; fs_high = 0; vs_falls = 0;
         end
         if (vo) vo_clks++;
         if (fs) fs_high++;
         if (!vo && (vif.VGA_Red || vif.VGA_Green || vif.VGA_Blue)) blank_err++;
         p_hs = hs; p_vs = vs; p_vo = vo; p_fs = fs;
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_fs(input int target, input int budget, input string name);
      int n = 0;
      while (fs_rises < target && n < budget) begin
         @(posedge clk);
         n++;
      end
      if (fs_rises < target) begin
         checks++; errors++;
         $display("FAIL %s: frame_start count %0d required %0d", name, fs_rises, target);
      end
   endtask

   int fs_base;
   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset("por");
      @(posedge clk);
      #1;
      push_frames(2);
      rst = 1'b0;

      wait_fs(2, 30000, "wait_second_frame");

      // Reset for one clock in the middle of line 7 of the second frame.
      repeat ((7 * 800 + 300) * 2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      exp_q.delete();
      push_frames(2);
      fs_base = fs_rises;
      rst = 1'b0;
      @(negedge clk);
      check_reset("midrst");

      wait_fs(fs_base + 2, 30000, "wait_after_reset");
      repeat (20) @(posedge clk);

      check("blank_leak", 32'(blank_err), 0);
      check("addr_max", 32'(max_addr), LAST_ADDR);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
